// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - states, opcodes and datapath select encodings
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ,
    JAL,
    HALT
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// rtl/imm_src_decoder.sv - opcode to immediate-format select
module imm_src_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_LW, OP_I: imm_src = IMM_I;
      OP_SW:       imm_src = IMM_S;
      OP_BEQ:      imm_src = IMM_B;
      OP_JAL:      imm_src = IMM_J;
      default:     imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RISC-V style control state machine
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       Halted
);

  state_t state_q, state_d;

  imm_src_decoder u_imm_src_decoder (
    .opcode  (opcode),
    .imm_src (ImmSrc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    Halted    = 1'b0;

    case (state_q)
      FETCH: begin
        MemReq    = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = ILLEGAL_HALT ? HALT : FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
        state_d = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (MemReady) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_MEM;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (MemReady) state_d = FETCH;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      BEQ: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        PCWrite   = Zero;
        state_d   = FETCH;
      end
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
        state_d   = ALUWB;
      end
      HALT: begin
        Halted  = 1'b1;
        state_d = HALT;
      end
      default: state_d = FETCH;
    endcase

    // A reset cycle must never commit architectural state, even mid-transfer.
    if (rst) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - vector table, corner sequences and random model check
module tb_multicycle_control_fsm;

  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_ILL = 7'b1111111;

  typedef struct packed {
    logic       mreq;
    logic       mwr;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] aop;
    logic [1:0] imm;
    logic       halt;
  } outs_t;

  typedef struct {
    logic       r;
    logic [6:0] op;
    logic       z;
    logic       rdy;
    outs_t      e;
  } vec_t;

  typedef enum int {S_IF, S_ID, S_AGEN, S_LOAD, S_LWB, S_STORE, S_EXR, S_EXI, S_WB, S_BR, S_JMP, S_STOP} step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       Zero;
  logic       MemReady;

  logic       MemReq0, MemWrite0, AdrSrc0, IRWrite0, PCWrite0, RegWrite0, Halted0;
  logic [1:0] ResultSrc0, ALUSrcA0, ALUSrcB0, ALUOp0, ImmSrc0;
  logic       MemReq1, MemWrite1, AdrSrc1, IRWrite1, PCWrite1, RegWrite1, Halted1;
  logic [1:0] ResultSrc1, ALUSrcA1, ALUSrcB1, ALUOp1, ImmSrc1;

  outs_t act0, act1;
  assign act0 = {MemReq0, MemWrite0, AdrSrc0, IRWrite0, PCWrite0, RegWrite0,
                 ResultSrc0, ALUSrcA0, ALUSrcB0, ALUOp0, ImmSrc0, Halted0};
  assign act1 = {MemReq1, MemWrite1, AdrSrc1, IRWrite1, PCWrite1, RegWrite1,
                 ResultSrc1, ALUSrcA1, ALUSrcB1, ALUOp1, ImmSrc1, Halted1};

  multicycle_control_fsm #(.ILLEGAL_HALT(1'b1)) dut_halt (
    .clk(clk), .rst(rst), .opcode(opcode), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq0), .MemWrite(MemWrite0), .AdrSrc(AdrSrc0), .IRWrite(IRWrite0),
    .PCWrite(PCWrite0), .RegWrite(RegWrite0), .ResultSrc(ResultSrc0), .ALUSrcA(ALUSrcA0),
    .ALUSrcB(ALUSrcB0), .ALUOp(ALUOp0), .ImmSrc(ImmSrc0), .Halted(Halted0)
  );

  multicycle_control_fsm #(.ILLEGAL_HALT(1'b0)) dut_skip (
    .clk(clk), .rst(rst), .opcode(opcode), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq1), .MemWrite(MemWrite1), .AdrSrc(AdrSrc1), .IRWrite(IRWrite1),
    .PCWrite(PCWrite1), .RegWrite(RegWrite1), .ResultSrc(ResultSrc1), .ALUSrcA(ALUSrcA1),
    .ALUSrcB(ALUSrcB1), .ALUOp(ALUOp1), .ImmSrc(ImmSrc1), .Halted(Halted1)
  );

  always #5 clk = ~clk;

  int    n_pass = 0;
  int    n_tot  = 0;
  vec_t  tbl[$];
  step_t plan[2][4];
  int    plen[2];
  int    pidx[2];

  function automatic outs_t o(int mreq, int mwr, int adr, int irw, int pcw, int rw,
                              int rs, int sa, int sb, int aop, int imm, int halt);
    outs_t e;
    e.mreq = 1'(mreq); e.mwr = 1'(mwr); e.adr = 1'(adr);
    e.irw  = 1'(irw);  e.pcw = 1'(pcw); e.rw  = 1'(rw);
    e.rs   = 2'(rs);   e.sa  = 2'(sa);  e.sb  = 2'(sb);
    e.aop  = 2'(aop);  e.imm = 2'(imm); e.halt = 1'(halt);
    return e;
  endfunction

  task automatic add(int r, logic [6:0] op, int z, int rdy, outs_t e);
    vec_t v;
    v = '{1'(r), op, 1'(z), 1'(rdy), e};
    tbl.push_back(v);
  endtask

  task automatic chk(string name, outs_t act, outs_t exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(logic r, logic [6:0] op, logic z, logic rdy);
    rst = r; opcode = op; Zero = z; MemReady = rdy;
    @(negedge clk);
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] imm_of(logic [6:0] op);
    if (op == T_LW || op == T_I) return 2'd0;
    if (op == T_SW)  return 2'd1;
    if (op == T_BEQ) return 2'd2;
    if (op == T_JAL) return 2'd3;
    return 2'd0;
  endfunction

  function automatic outs_t expect_out(step_t s, logic [6:0] op, logic z, logic rdy, logic r);
    outs_t e;
    e = '0;
    case (s)
      S_IF:    begin e.mreq = 1; e.sb = 2; e.rs = 2; e.irw = rdy; e.pcw = rdy; end
      S_ID:    begin e.sa = 1; e.sb = 1; end
      S_AGEN:  begin e.sa = 2; e.sb = 1; end
      S_LOAD:  begin e.mreq = 1; e.adr = 1; end
      S_LWB:   begin e.rs = 1; e.rw = 1; end
      S_STORE: begin e.mreq = 1; e.mwr = 1; e.adr = 1; end
      S_EXR:   begin e.sa = 2; e.aop = 2; end
      S_EXI:   begin e.sa = 2; e.sb = 1; e.aop = 2; end
      S_WB:    e.rw = 1;
      S_BR:    begin e.sa = 2; e.aop = 1; e.pcw = z; end
      S_JMP:   begin e.sa = 1; e.sb = 2; e.pcw = 1; end
      default: e.halt = 1;
    endcase
    e.imm = imm_of(op);
    if (r) begin e.irw = 0; e.pcw = 0; e.rw = 0; e.mwr = 0; end
    return e;
  endfunction

  function automatic step_t cur(int d);
    return (pidx[d] < 0) ? S_IF : plan[d][pidx[d]];
  endfunction

  // Each instruction is a list of steps taken after its fetch completes.
  task automatic build(int d, bit ih);
    plan[d][0] = S_ID;
    case (opcode)
      T_LW:  begin plan[d][1] = S_AGEN; plan[d][2] = S_LOAD; plan[d][3] = S_LWB; plen[d] = 4; end
      T_SW:  begin plan[d][1] = S_AGEN; plan[d][2] = S_STORE; plen[d] = 3; end
      T_R:   begin plan[d][1] = S_EXR; plan[d][2] = S_WB; plen[d] = 3; end
      T_I:   begin plan[d][1] = S_EXI; plan[d][2] = S_WB; plen[d] = 3; end
      T_BEQ: begin plan[d][1] = S_BR; plen[d] = 2; end
      T_JAL: begin plan[d][1] = S_JMP; plan[d][2] = S_WB; plen[d] = 3; end
      default: begin
        plan[d][1] = S_STOP;
        plen[d] = ih ? 2 : 1;
      end
    endcase
  endtask

  task automatic advance(int d, bit ih);
    step_t s;
    bit    waiting;
    s = cur(d);
    waiting = (s == S_IF || s == S_LOAD || s == S_STORE) && !MemReady;
    if (rst) begin
      pidx[d] = -1;
    end else if (s != S_STOP && !waiting) begin
      if (pidx[d] < 0) begin
        build(d, ih);
        pidx[d] = 0;
      end else begin
        pidx[d]++;
        if (pidx[d] == plen[d]) pidx[d] = -1;
      end
    end
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] r;
    r = 7'($urandom);
    case ($urandom_range(0, 7))
      0: return T_R;
      1: return T_I;
      2: return T_LW;
      3: return T_SW;
      4: return T_BEQ;
      5: return T_JAL;
      6: return T_ILL;
      default: return r;
    endcase
  endfunction

  initial begin
    rst = 1'b1; opcode = T_R; Zero = 1'b0; MemReady = 1'b0;
    step_clk();

    // reset, add
    add(1, T_R, 0, 1, o(1,0,0,0,0,0, 2,0,2,0,0, 0));
    add(0, T_R, 0, 1, o(1,0,0,1,1,0, 2,0,2,0,0, 0));
    add(0, T_R, 0, 1, o(0,0,0,0,0,0, 0,1,1,0,0, 0));
    add(0, T_R, 0, 1, o(0,0,0,0,0,0, 0,2,0,2,0, 0));
    add(0, T_R, 0, 1, o(0,0,0,0,0,1, 0,0,0,0,0, 0));
    // lw with two memory wait cycles
    add(0, T_LW, 0, 1, o(1,0,0,1,1,0, 2,0,2,0,0, 0));
    add(0, T_LW, 0, 1, o(0,0,0,0,0,0, 0,1,1,0,0, 0));
    add(0, T_LW, 0, 1, o(0,0,0,0,0,0, 0,2,1,0,0, 0));
    add(0, T_LW, 0, 0, o(1,0,1,0,0,0, 0,0,0,0,0, 0));
    add(0, T_LW, 0, 0, o(1,0,1,0,0,0, 0,0,0,0,0, 0));
    add(0, T_LW, 0, 1, o(1,0,1,0,0,0, 0,0,0,0,0, 0));
    add(0, T_LW, 0, 1, o(0,0,0,0,0,1, 1,0,0,0,0, 0));
    // beq taken, then not taken
    add(0, T_BEQ, 1, 1, o(1,0,0,1,1,0, 2,0,2,0,2, 0));
    add(0, T_BEQ, 1, 1, o(0,0,0,0,0,0, 0,1,1,0,2, 0));
    add(0, T_BEQ, 1, 1, o(0,0,0,0,1,0, 0,2,0,1,2, 0));
    add(0, T_BEQ, 0, 1, o(1,0,0,1,1,0, 2,0,2,0,2, 0));
    add(0, T_BEQ, 0, 1, o(0,0,0,0,0,0, 0,1,1,0,2, 0));
    add(0, T_BEQ, 0, 1, o(0,0,0,0,0,0, 0,2,0,1,2, 0));
    // jal
    add(0, T_JAL, 0, 1, o(1,0,0,1,1,0, 2,0,2,0,3, 0));
    add(0, T_JAL, 0, 1, o(0,0,0,0,0,0, 0,1,1,0,3, 0));
    add(0, T_JAL, 0, 1, o(0,0,0,0,1,0, 0,1,2,0,3, 0));
    add(0, T_JAL, 0, 1, o(0,0,0,0,0,1, 0,0,0,0,3, 0));
    // sw interrupted by reset while MemReady arrives
    add(0, T_SW, 0, 1, o(1,0,0,1,1,0, 2,0,2,0,1, 0));
    add(0, T_SW, 0, 1, o(0,0,0,0,0,0, 0,1,1,0,1, 0));
    add(0, T_SW, 0, 1, o(0,0,0,0,0,0, 0,2,1,0,1, 0));
    add(0, T_SW, 0, 0, o(1,1,1,0,0,0, 0,0,0,0,1, 0));
    add(1, T_SW, 0, 1, o(1,0,1,0,0,0, 0,0,0,0,1, 0));
    add(0, T_SW, 0, 0, o(1,0,0,0,0,0, 2,0,2,0,1, 0));
    // illegal opcode parks in HALT
    add(0, T_ILL, 0, 1, o(1,0,0,1,1,0, 2,0,2,0,0, 0));
    add(0, T_ILL, 0, 1, o(0,0,0,0,0,0, 0,1,1,0,0, 0));
    add(0, T_ILL, 0, 1, o(0,0,0,0,0,0, 0,0,0,0,0, 1));
    add(0, T_ILL, 1, 1, o(0,0,0,0,0,0, 0,0,0,0,0, 1));
    add(0, T_ILL, 1, 0, o(0,0,0,0,0,0, 0,0,0,0,0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].op, tbl[i].z, tbl[i].rdy);
      chk($sformatf("tbl%0d", i), act0, tbl[i].e);
      step_clk();
    end

    // Illegal opcode with and without halting, then reset out of HALT.
    drive(1, T_ILL, 0, 1);
    chk("ill_rst_skip", act1, o(1,0,0,0,0,0, 2,0,2,0,0, 0));
    step_clk();
    drive(0, T_ILL, 0, 1);
    chk("ill_fetch_skip", act1, o(1,0,0,1,1,0, 2,0,2,0,0, 0));
    step_clk();
    drive(0, T_ILL, 0, 1);
    chk("ill_decode_skip", act1, o(0,0,0,0,0,0, 0,1,1,0,0, 0));
    step_clk();
    drive(0, T_ILL, 0, 0);
    chk("ill_back_to_fetch", act1, o(1,0,0,0,0,0, 2,0,2,0,0, 0));
    chk("ill_halted", act0, o(0,0,0,0,0,0, 0,0,0,0,0, 1));
    step_clk();
    drive(1, T_R, 0, 1);
    chk("halt_in_rst", act0, o(0,0,0,0,0,0, 0,0,0,0,0, 1));
    step_clk();
    drive(0, T_R, 0, 0);
    chk("halt_released", act0, o(1,0,0,0,0,0, 2,0,2,0,0, 0));
    step_clk();

    // Random traffic against the instruction-plan model on both variants.
    drive(1, T_R, 0, 0);
    step_clk();
    pidx[0] = -1;
    pidx[1] = -1;
    for (int c = 0; c < 3000; c++) begin
      logic       r, z, rdy;
      logic [6:0] op;
      step_t      s0, s1;
      s0 = cur(0);
      s1 = cur(1);
      op = opcode;
      if ((s0 == S_IF || s0 == S_STOP) && (s1 == S_IF || s1 == S_STOP) && $urandom_range(0, 2) == 0)
        op = pick_op();
      r   = ($urandom_range(0, 39) == 0);
      z   = 1'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      drive(r, op, z, rdy);
      chk($sformatf("rand_halt%0d", c), act0, expect_out(s0, op, z, rdy, r));
      chk($sformatf("rand_skip%0d", c), act1, expect_out(s1, op, z, rdy, r));
      @(posedge clk);
      advance(0, 1'b1);
      advance(1, 1'b0);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have parameter ILLEGAL_HALT, default 1: 1 = unsupported opcode enters HALT; 0 = unsupported opcode returns to FETCH.
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports clk, rst.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 opcode  in  7  instruction-register opcode, stable from DECODE until the next IRWrite.
REQ-006 Zero  in  1  ALU zero flag.
REQ-007 MemReady  in  1  memory completion; accepted only while MemReq=1.
REQ-008 MemReq  out  1  memory access request, held until MemReady.
REQ-009 MemWrite  out  1  store strobe, valid with MemReq.
REQ-010 AdrSrc  out  1  0 = PC address, 1 = ALUOut address.
REQ-011 IRWrite  out  1  latch instruction.
REQ-012 PCWrite  out  1  PC update enable.
REQ-013 RegWrite  out  1  register-file write enable.
REQ-014 ResultSrc  out  2  00 ALUOut, 01 mem data, 10 ALU result.
REQ-015 ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1.
REQ-016 ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4.
REQ-017 ALUOp  out  2  00 add, 01 subtract/compare, 10 funct-decoded.
REQ-018 ImmSrc  out  2  00 I, 01 S, 10 B, 11 J.
REQ-019 Halted  out  1  FSM parked in HALT.

Function
REQ-020 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, HALT; outputs are Moore, except the gated strobes named below.
REQ-021 Every output not listed for a state SHALL be 0; no x values on any output.
REQ-022 ImmSrc SHALL be decoded from opcode in every state: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, other -> 00.
REQ-023 FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10; IRWrite and PCWrite asserted only in the cycle MemReady=1; then -> DECODE; otherwise stay.
REQ-024 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target to ALUOut).
REQ-025 DECODE next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; other -> HALT if ILLEGAL_HALT else FETCH.
REQ-026 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; -> MEMREAD if opcode=0000011, else -> MEMWRITE.
REQ-027 MEMREAD: MemReq=1, AdrSrc=1; -> MEMWB on MemReady.
REQ-028 MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
REQ-029 MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1, held until MemReady; -> FETCH on MemReady.
REQ-030 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both -> ALUWB.
REQ-031 ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
REQ-032 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero (combinational); -> FETCH.
REQ-033 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; -> ALUWB.
REQ-034 HALT: Halted=1, all strobes 0; leaves only via rst.
REQ-035 With zero-wait memory (MemReady=1 on first request cycle), latency in cycles: beq 3; R, I, sw, jal 4; lw 5. Each MemReady wait cycle adds 1.
REQ-036 MemReady while MemReq=0 SHALL be ignored.

Reset
REQ-037 rst=1 at a clock edge SHALL force FETCH on the next cycle, from any state, including mid-wait in MEMREAD/MEMWRITE.
REQ-038 rst SHALL take priority over MemReady in the same cycle; no IRWrite, PCWrite, RegWrite or MemWrite in the reset cycle.
REQ-039 After reset: MemReq=1, AdrSrc=0, Halted=0; all other strobes 0.

Structure
REQ-040 Shared package SHALL hold state enum, opcode constants (OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL) and the ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc encodings.
REQ-041 One sub-module, imm_src_decoder (opcode -> ImmSrc), SHALL be instantiated; the rest is one state register plus next-state/output logic.

Verification
REQ-042 add (0110011), MemReady tied 1 -> FETCH, DECODE, EXECUTER, ALUWB; RegWrite=1 only in cycle 4; IRWrite/PCWrite=1 only in cycle 1.
REQ-043 lw (0000011), MemReady low for 2 cycles in MEMREAD -> MemReq/AdrSrc=1 held for 3 cycles, then MEMWB with ResultSrc=01, RegWrite=1; total 7 cycles.
REQ-044 beq (1100011) run twice, Zero=1 then Zero=0 -> PCWrite=1 in BEQ only for the first; both return to FETCH after 3 cycles.
REQ-045 jal (1101111) -> JAL PCWrite=1 with ALUSrcA=01, ALUSrcB=10; then ALUWB RegWrite=1; ImmSrc=11 throughout.
REQ-046 opcode 1111111: ILLEGAL_HALT=1 -> Halted=1 and stays with all strobes 0; ILLEGAL_HALT=0 -> FETCH after DECODE.
REQ-047 rst=1 in MEMWRITE with MemReady=1 in the same cycle -> no completed write; FETCH on the next cycle with MemWrite=0.
